shift_cmd_queue: RTL

//  Upstream command stage for the doubler/shifter with operation counter.

---
 rtl/shift_cmd_pkg.sv | 15 +
 rtl/shift_cmd_mem.sv | 26 ++
 rtl/shift_cmd_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/shift_cmd_pkg.sv
// Shared definitions for the shifter command stage: default widths, the NOP control code
// and the command record layout.
package shift_cmd_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned CTRL_W_DEF = 3;

  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = 3'h0;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [CTRL_W_DEF-1:0] control;
  } cmd_t;

endpackage

// File: rtl/shift_cmd_mem.sv
// Command storage: Depth x Width register array, one synchronous write port and one
// asynchronous read port.
module shift_cmd_mem #(
  parameter int unsigned Width = 7,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PtrW-1:0]  wr_ptr,
  input  logic [Width-1:0] wr_data,
  input  logic [PtrW-1:0]  rd_ptr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/shift_cmd_queue.sv
// Command FIFO in front of the doubler/shifter: issues at most one command per clock and
// drives NOP otherwise. Define CMD_QUEUE_DROP_CNT_EN to add the saturating drop_cnt output.
module shift_cmd_queue
  import shift_cmd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_control,
  input  logic              issue_en,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_control,
  output logic              out_issue,
  output logic [LvlW-1:0]   level,
  output logic              full,
  output logic              empty
`ifdef CMD_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int unsigned EntW = DATA_W + CTRL_W;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_control_q, out_control_d;
  logic              out_issue_q, out_issue_d;
  logic [EntW-1:0]   head;
  logic              push, pop;

  assign full     = (level_q == LvlW'(DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = !full || issue_en;
  assign push     = in_valid && in_ready;
  assign pop      = issue_en && !empty;

  shift_cmd_mem #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push && !flush),
    .wr_ptr  (wr_ptr_q),
    .wr_data ({in_data, in_control}),
    .rd_ptr  (rd_ptr_q),
    .rd_data (head)
  );

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    out_data_d    = '0;
    out_control_d = CTRL_W'(NOP_CTRL);
    out_issue_d   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + 1'b1;
        out_data_d    = head[EntW-1:CTRL_W];
        out_control_d = head[CTRL_W-1:0];
        out_issue_d   = 1'b1;
      end
      level_d = level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_data_q    <= '0;
      out_control_q <= CTRL_W'(NOP_CTRL);
      out_issue_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_data_q    <= out_data_d;
      out_control_q <= out_control_d;
      out_issue_q   <= out_issue_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_control = out_control_q;
  assign out_issue   = out_issue_q;
  assign level       = level_q;

`ifdef CMD_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Flush does not clear this; only reset does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (in_valid && !in_ready && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
